jesd204_rx_fec_monitor: RTL

JESD204_RX_FEC_MONITOR -- requirements
Module: jesd204_rx_fec_monitor

---
 rtl/jesd204_rx_fec_monitor_if.sv | 29 ++
 rtl/jesd204_rx_fec_monitor.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/jesd204_rx_fec_monitor_if.sv
// Bus between the JESD204 RX lane FEC decoders / link control and the FEC health monitor.
// The master side drives the link status and the error flags; the slave side is the monitor.
interface jesd204_rx_fec_monitor_if #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 link_up;
  logic                 eomb;
  logic [NUM_LANES-1:0] lane_en;
  logic [NUM_LANES-1:0] lane_trapped_err;
  logic [NUM_LANES-1:0] lane_untrapped_err;
  logic                 clear;
  logic [7:0]           sel_lane;
  logic [CNT_WIDTH-1:0] trapped_cnt;
  logic [CNT_WIDTH-1:0] untrapped_cnt;
  logic [15:0]          window_errs;
  logic [1:0]           state;
  logic                 state_change;

  modport master (
    output link_up, eomb, lane_en, lane_trapped_err, lane_untrapped_err, clear, sel_lane,
    input  trapped_cnt, untrapped_cnt, window_errs, state, state_change
  );

  modport slave (
    input  link_up, eomb, lane_en, lane_trapped_err, lane_untrapped_err, clear, sel_lane,
    output trapped_cnt, untrapped_cnt, window_errs, state, state_change
  );
endinterface

// File: rtl/jesd204_rx_fec_monitor.sv
// Per-lane FEC error counters plus a windowed link-health FSM (IDLE/GOOD/DEGRADED/FAILED)
// driven by untrapped-error counts per window of WINDOW_MB multiblocks.
module jesd204_rx_fec_monitor #(
  parameter int unsigned NUM_LANES       = 4,
  parameter int unsigned CNT_WIDTH       = 32,
  parameter int unsigned WINDOW_MB       = 256,
  parameter int unsigned DEGRADE_THRESH  = 4,
  parameter int unsigned FAIL_THRESH     = 16,
  parameter int unsigned RECOVER_WINDOWS = 4
) (
  input logic                     clk,
  input logic                     rst,
  jesd204_rx_fec_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StGood     = 2'd1,
    StDegraded = 2'd2,
    StFailed   = 2'd3
  } state_e;

  state_e               state_q;
  logic                 state_change_q;
  logic [15:0]          window_errs_q;
  logic [15:0]          mb_cnt_q;
  logic [15:0]          clean_cnt_q;
  logic [CNT_WIDTH-1:0] trap_cnt_q   [NUM_LANES];
  logic [CNT_WIDTH-1:0] untrap_cnt_q [NUM_LANES];
  logic [CNT_WIDTH-1:0] rd_trap_q;
  logic [CNT_WIDTH-1:0] rd_untrap_q;

  logic [16:0]          n_untrap;
  logic [16:0]          errs_sum;
  logic [15:0]          errs_now;
  logic                 active;
  logic                 win_end;
  logic [CNT_WIDTH-1:0] rd_trap_d;
  logic [CNT_WIDTH-1:0] rd_untrap_d;

  // errs_now is the window total including this cycle's errors (the E used at window end).
  always_comb begin
    n_untrap = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (mon.lane_en[i] && mon.lane_untrapped_err[i]) begin
        n_untrap = n_untrap + 17'd1;
      end
    end
    errs_sum = {1'b0, window_errs_q} + n_untrap;
    errs_now = errs_sum[16] ? 16'hFFFF : errs_sum[15:0];
    active   = (state_q != StIdle) && mon.link_up && !mon.clear;
    win_end  = active && mon.eomb && (mb_cnt_q == 16'(WINDOW_MB - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      state_change_q <= 1'b0;
      window_errs_q  <= '0;
      mb_cnt_q       <= '0;
      clean_cnt_q    <= '0;
    end else begin
      state_change_q <= 1'b0;
      if (!mon.link_up) begin
        state_q        <= StIdle;
        state_change_q <= (state_q != StIdle);
        window_errs_q  <= '0;
        mb_cnt_q       <= '0;
        clean_cnt_q    <= '0;
      end else if (mon.clear) begin
        state_q        <= StGood;
        state_change_q <= (state_q != StGood);
        window_errs_q  <= '0;
        mb_cnt_q       <= '0;
        clean_cnt_q    <= '0;
      end else if (state_q == StIdle) begin
        state_q        <= StGood;
        state_change_q <= 1'b1;
      end else if (win_end) begin
        window_errs_q <= '0;
        mb_cnt_q      <= '0;
        case (state_q)
          StGood: begin
            if (32'(errs_now) >= FAIL_THRESH) begin
              state_q        <= StFailed;
              state_change_q <= 1'b1;
            end else if (32'(errs_now) >= DEGRADE_THRESH) begin
              state_q        <= StDegraded;
              state_change_q <= 1'b1;
              clean_cnt_q    <= '0;
            end
          end
          StDegraded: begin
            if (32'(errs_now) >= FAIL_THRESH) begin
              state_q        <= StFailed;
              state_change_q <= 1'b1;
            end else if (errs_now != 16'd0) begin
              clean_cnt_q <= '0;
            end else if (32'(clean_cnt_q) + 32'd1 >= RECOVER_WINDOWS) begin
              state_q        <= StGood;
              state_change_q <= 1'b1;
              clean_cnt_q    <= '0;
            end else begin
              clean_cnt_q <= clean_cnt_q + 16'd1;
            end
          end
          default: ;
        endcase
      end else begin
        window_errs_q <= errs_now;
        if (mon.eomb) begin
          mb_cnt_q <= mb_cnt_q + 16'd1;
        end
      end
    end
  end

  always_comb begin
    rd_trap_d   = '0;
    rd_untrap_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (mon.sel_lane == 8'(i)) begin
        rd_trap_d   = trap_cnt_q[i];
        rd_untrap_d = untrap_cnt_q[i];
      end
    end
  end

  // Counters freeze while the link is down (state falls to IDLE) and saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        trap_cnt_q[i]   <= '0;
        untrap_cnt_q[i] <= '0;
      end
      rd_trap_q   <= '0;
      rd_untrap_q <= '0;
    end else begin
      rd_trap_q   <= rd_trap_d;
      rd_untrap_q <= rd_untrap_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (mon.clear) begin
          trap_cnt_q[i]   <= '0;
          untrap_cnt_q[i] <= '0;
        end else if (active && mon.lane_en[i]) begin
          if (mon.lane_trapped_err[i] && !(&trap_cnt_q[i])) begin
            trap_cnt_q[i] <= trap_cnt_q[i] + 1'b1;
          end
          if (mon.lane_untrapped_err[i] && !(&untrap_cnt_q[i])) begin
            untrap_cnt_q[i] <= untrap_cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  assign mon.state         = state_q;
  assign mon.state_change  = state_change_q;
  assign mon.window_errs   = window_errs_q;
  assign mon.trapped_cnt   = rd_trap_q;
  assign mon.untrapped_cnt = rd_untrap_q;

endmodule
